// File: rtl/uart_tx_buf_pkg.sv
// Shared constants for uart_tx_buf: register addresses, STATUS bit positions, serializer states.
package uart_tx_buf_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'h4000_0018;
  localparam logic [31:0] STATUS_ADDR = 32'h4000_0020;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_IRQ_EN  = 3;
  localparam int ST_DONE    = 4;
  localparam int ST_OVF     = 5;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO, push/pop take effect on the same edge; dout is the head, valid when not empty.
// Push into a full FIFO is accepted only when a pop happens on that edge, otherwise dropped.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    dout
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Memory-mapped buffered 8N1 UART transmitter; tx falls one edge after a TXDATA write to an idle unit.
// A write to a full FIFO is dropped and flags overflow; the CPU bus never stalls.
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int BAUD_DIV = 5208,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

  tx_state_t      state, state_nxt;
  logic [15:0]    baud_cnt, baud_cnt_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           period_end;
  logic           irq_en, done_pend, overflow;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     fifo_dout;
  logic           wr_txdata, wr_status, set_done, drop;
  logic [31:0]    status;
  logic           unused_wdata;

  assign wr_txdata    = mem_wr && (addr == TXDATA_ADDR);
  assign wr_status    = mem_wr && (addr == STATUS_ADDR);
  assign drop         = wr_txdata && fifo_full && !fifo_pop;
  assign set_done     = (state == STOP) && period_end && fifo_empty && !wr_txdata;
  assign irq          = done_pend && irq_en;
  assign unused_wdata = ^wdata[31:8];

  tx_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    fifo_pop     = 1'b0;
    tx           = 1'b1;
    period_end   = (baud_cnt == '0);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_nxt    = fifo_dout;
          baud_cnt_nxt = RELOAD;
          state_nxt    = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (period_end) begin
          state_nxt    = DATA;
          bit_idx_nxt  = '0;
          baud_cnt_nxt = RELOAD;
        end else begin
          baud_cnt_nxt = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        tx = shift[0];
        if (period_end) begin
          shift_nxt    = {1'b0, shift[7:1]};
          baud_cnt_nxt = RELOAD;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          baud_cnt_nxt = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (period_end) state_nxt    = IDLE;
        else            baud_cnt_nxt = baud_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hardware set beats a simultaneous software clear so no completion is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en    <= 1'b0;
      done_pend <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_status) irq_en <= wdata[ST_IRQ_EN];
      if (set_done)                          done_pend <= 1'b1;
      else if (wr_status && wdata[ST_DONE])  done_pend <= 1'b0;
      if (drop)                              overflow  <= 1'b1;
      else if (wr_status && wdata[ST_OVF])   overflow  <= 1'b0;
    end
  end

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_BUSY]            = (state != IDLE);
    status[ST_IRQ_EN]          = irq_en;
    status[ST_DONE]            = done_pend;
    status[ST_OVF]             = overflow;
    status[ST_CNT_LSB +: 4]    = 4'(fifo_count);
  end

  assign rdata = (mem_rd && (addr == STATUS_ADDR)) ? status : 32'h0;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with BAUD_DIV=4, DEPTH=4; inputs change and outputs are sampled on negedge.
module tb_uart_tx_buf;
  import uart_tx_buf_pkg::*;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [31:0] v;
  logic [39:0] fb;
  int          wc;

  uart_tx_buf #(.BAUD_DIV(BD), .DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_wr (mem_wr),
    .mem_rd (mem_rd),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .tx     (tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_wr = 1'b1;
    addr   = a;
    wdata  = d;
    @(negedge clk);
    mem_wr = 1'b0;
    addr   = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_rd = 1'b1;
    addr   = a;
    #1;
    d      = rdata;
    mem_rd = 1'b0;
    addr   = '0;
  endtask

  // Expected tx per clock: 4 start, 8 data bits LSB first, 4 stop.
  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [39:0] f;
    int p;
    for (int j = 0; j < 40; j++) begin
      p = j / BD;
      if (p == 0)      f[j] = 1'b0;
      else if (p == 9) f[j] = 1'b1;
      else             f[j] = b[p-1];
    end
    return f;
  endfunction

  task automatic grab_frame(output logic [39:0] bits, output int wait_cyc);
    wait_cyc = 0;
    bits     = '1;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (tx !== 1'b0 && wait_cyc < 60);
    bits[0] = tx;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      bits[j] = tx;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b0);
    bus_read(STATUS_ADDR, v);
    check("rst_status", v, 32'h2);
    reset = 1'b1;
    @(negedge clk);

    // Single frame 0xA5, exact latency and bit timing
    bus_write(TXDATA_ADDR, 32'h0000_00A5);
    check("a5_pre_tx", tx, 1'b1);
    grab_frame(fb, wc);
    check("a5_latency", wc, 1);
    check("a5_frame", fb, frame_of(8'hA5));
    @(negedge clk);
    bus_read(STATUS_ADDR, v);
    check("a5_status_done", v, 32'h12);
    check("a5_irq_masked", irq, 1'b0);

    // Unmapped reads and read strobe gating
    bus_read(TXDATA_ADDR, v);
    check("rd_txdata_zero", v, 32'h0);
    bus_read(32'h8000_0000, v);
    check("rd_other_zero", v, 32'h0);
    addr = STATUS_ADDR;
    #1;
    check("rd_no_strobe", rdata, 32'h0);
    addr = '0;

    // Interrupt: enable, clear done, send 0x3C
    @(negedge clk);
    bus_write(STATUS_ADDR, 32'h18);
    bus_read(STATUS_ADDR, v);
    check("irqen_status", v, 32'h0A);
    bus_write(TXDATA_ADDR, 32'hDEAD_BE3C);
    grab_frame(fb, wc);
    check("3c_latency", wc, 1);
    check("3c_frame", fb, frame_of(8'h3C));
    check("irq_before_done", irq, 1'b0);
    @(negedge clk);
    check("irq_at_done", irq, 1'b1);
    bus_read(STATUS_ADDR, v);
    check("done_status", v, 32'h1A);
    @(negedge clk);
    bus_write(STATUS_ADDR, 32'h18);
    check("irq_cleared", irq, 1'b0);

    // Clear on the same edge done_pend sets: set wins
    bus_write(TXDATA_ADDR, 32'h81);
    grab_frame(fb, wc);
    check("81_frame", fb, frame_of(8'h81));
    bus_write(STATUS_ADDR, 32'h18);
    check("set_wins", irq, 1'b1);
    bus_write(STATUS_ADDR, 32'h18);
    check("irq_cleared2", irq, 1'b0);

    // Six back-to-back writes into a depth-4 FIFO
    fork
      begin : writer
        logic [31:0] sv;
        for (int i = 0; i < 6; i++) begin
          mem_wr = 1'b1;
          addr   = TXDATA_ADDR;
          wdata  = {24'hFFFFFF, burst[i]};
          @(negedge clk);
        end
        mem_wr = 1'b0;
        addr   = '0;
        bus_read(STATUS_ADDR, sv);
        check("burst_status", sv, 32'h42D);
        bus_write(STATUS_ADDR, 32'h08);
      end
      begin : reader
        logic [39:0] rb;
        int rw;
        for (int f = 0; f < 5; f++) begin
          grab_frame(rb, rw);
          check($sformatf("burst_gap%0d", f), rw, 2);
          check($sformatf("burst_frame%0d", f), rb, frame_of(burst[f]));
        end
      end
    join
    @(negedge clk);
    bus_read(STATUS_ADDR, v);
    check("burst_end_status", v, 32'h3A);
    @(negedge clk);
    bus_write(STATUS_ADDR, 32'h38);
    bus_read(STATUS_ADDR, v);
    check("ovf_cleared", v, 32'h0A);

    // Reset during DATA bit 3 with one byte queued
    @(negedge clk);
    bus_write(TXDATA_ADDR, 32'h33);
    bus_write(TXDATA_ADDR, 32'h77);
    repeat (16) @(negedge clk);
    check("mid_bit3_tx", tx, 1'b0);
    bus_read(STATUS_ADDR, v);
    check("mid_status", v, 32'h10C);
    reset = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_irq", irq, 1'b0);
    bus_read(STATUS_ADDR, v);
    check("abort_status", v, 32'h2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_write(TXDATA_ADDR, 32'hC3);
    grab_frame(fb, wc);
    check("post_rst_latency", wc, 1);
    check("post_rst_frame", fb, frame_of(8'hC3));
    @(negedge clk);
    bus_read(STATUS_ADDR, v);
    check("post_rst_status", v, 32'h12);
    check("post_rst_irq", irq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
